// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, byte/address types and prefetch fill-control states
package cpu_pkg;

  localparam int AW = 16;
  localparam int DW = 8;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] byte_t;

  typedef enum logic [1:0] {
    PF_FILL,
    PF_HOLD,
    PF_FLUSH
  } pf_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - small byte FIFO with flush, occupancy count and registered head output
module byte_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rd_next = rd_ptr + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
      // Head register always mirrors the entry at rd_ptr so byte_data needs no read mux.
      if (do_pop)
        head <= (count == CW'(1)) ? push_data : mem[rd_next];
      else if (do_push && (count == '0))
        head <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - byte-wide instruction prefetch with redirect flush and memory-port yield
// Optional PREFETCH_PERF_EN adds saturating flush/stall performance counters.
module instr_prefetch #(
  parameter int             AW         = 16,
  parameter int             DW         = 8,
  parameter int             DEPTH      = 4,
  parameter logic [AW-1:0]  RESET_ADDR = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mem_grant,
  output logic           mem_rd_en,
  output logic [AW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           redirect,
  input  logic [AW-1:0]  redirect_addr,
  output logic           byte_valid,
  output logic [DW-1:0]  byte_data,
  input  logic           byte_pop,
  output logic [AW-1:0]  head_addr
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]    perf_flush_cnt,
  output logic [15:0]    perf_stall_cnt
`endif
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t      state;
  pf_state_t      state_next;
  logic [AW-1:0]  fetch_addr;
  logic           inflight;
  logic           discard;
  logic           push;
  logic           pop;
  logic           credit_ok;
  logic [CW-1:0]  count;
  logic [CW:0]    used;

  // Credits count both stored bytes and the read still on its way back.
  assign used       = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign credit_ok  = used < (CW+1)'(DEPTH);
  assign push       = inflight && !redirect && !((state == PF_FLUSH) && discard);
  assign byte_valid = (count != '0);
  assign pop        = byte_pop && byte_valid && !redirect;
  assign mem_addr   = fetch_addr;

  byte_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pop),
    .flush     (redirect),
    .head      (byte_data),
    .count     (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PF_FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    if (redirect) begin
      state_next = PF_FLUSH;
    end else if (mem_grant && credit_ok && !reset) begin
      mem_rd_en  = 1'b1;
      state_next = PF_FILL;
    end else begin
      state_next = PF_HOLD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr <= RESET_ADDR;
      head_addr  <= RESET_ADDR;
      inflight   <= 1'b0;
      discard    <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      discard  <= redirect && inflight;
      if (redirect) begin
        fetch_addr <= redirect_addr;
        head_addr  <= redirect_addr;
      end else begin
        if (mem_rd_en) fetch_addr <= fetch_addr + AW'(1);
        if (pop)       head_addr  <= head_addr + AW'(1);
      end
    end
  end

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (redirect && (perf_flush_cnt != 16'hFFFF))
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      if (!byte_valid && !redirect && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
